// File: rtl/inverse_host_sequencer_pkg.sv
// inverse_host_sequencer_pkg: sequencer state encoding, idle command and opcode constants
package inverse_host_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CMD, WAIT, RADDR, RWAIT, SEND} state_t;
  localparam logic [5:0] CMD_IDLE = 6'h00;
  localparam logic [5:0] OP_MUL = 6'h01;
  localparam logic [5:0] OP_INV = 6'h05;
endpackage

// File: rtl/inverse_host_sequencer_width_serdes.sv
// width_serdes: WORD<->Data shift register with word counter
// clr/ld/step: clear, parallel load, shift one word in at the top; q: low OW bits; last: counter at N-1
module width_serdes import inverse_host_sequencer_pkg::*; #(
  parameter int Data = 256,
  parameter int WORD = 32,
  parameter int OW = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            ld,
  input  logic [Data-1:0] par_in,
  input  logic            step,
  input  logic [WORD-1:0] word_in,
  output logic [OW-1:0]   q,
  output logic            last
);
  localparam int N = Data / WORD;
  localparam int CW = $clog2(N) + 1;
  logic [Data-1:0] sr;
  logic [CW-1:0] k;
  // shifting right by a word lands beat k at [k*WORD +: WORD] after N beats, and exposes word j at the bottom when sending
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr <= '0;
      k <= '0;
    end else if (ld) begin
      sr <= par_in;
      k <= '0;
    end else if (step) begin
      sr <= {word_in, sr[Data-1:WORD]};
      k <= k + 1'b1;
    end
  end
  assign q = sr[OW-1:0];
  assign last = k == CW'(N - 1);
endmodule

// File: rtl/inverse_host_sequencer.sv
// inverse_host_sequencer: host-side initiator that loads an operand, commands the inverse block and streams the result
// start/start_cmd/src_addr/dst_addr: operation request; busy/done: status
// in_*: narrow operand stream in; out_*: narrow result stream out (LSW first)
// wr_en/Addr/Data_in/Data_Out: RAM host port; Command: one-cycle command to the state machine
module inverse_host_sequencer #(
  parameter int Data = 256,
  parameter int addr = 6,
  parameter int Command_len = 6,
  parameter int WORD = 32,
  parameter int CMD_CYCLES = 1024,
  parameter int RD_LAT = 1,
  parameter logic [Command_len-1:0] CMD_IDLE = Command_len'(inverse_host_sequencer_pkg::CMD_IDLE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [Command_len-1:0] start_cmd,
  input  logic [addr-1:0]        src_addr,
  input  logic [addr-1:0]        dst_addr,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD-1:0]        out_data,
  output logic                   out_last,
  output logic                   wr_en,
  output logic [addr-1:0]        Addr,
  output logic [Data-1:0]        Data_in,
  input  logic [Data-1:0]        Data_Out,
  output logic [Command_len-1:0] Command
);
  import inverse_host_sequencer_pkg::*;
  localparam int CT = CMD_CYCLES > RD_LAT ? CMD_CYCLES : RD_LAT;
  localparam int CW = $clog2(CT) + 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [Command_len-1:0] cmd_r;
  logic [addr-1:0] src_r, dst_r;
  logic beat, acc, last_l, last_s, wait_end, rd_end, idle;
  assign idle = state == IDLE;
  assign beat = in_valid && in_ready;
  assign acc = out_valid && out_ready;
  assign wait_end = state == WAIT && cnt == CW'(CMD_CYCLES - 1);
  assign rd_end = state == RWAIT && cnt == CW'(RD_LAT - 1);
  assign busy = !idle;
  assign in_ready = state == LOAD;
  assign wr_en = state == WRITE;
  assign out_valid = state == SEND;
  assign out_last = out_valid && last_s;
  assign Command = state == CMD ? cmd_r : CMD_IDLE;
  assign Addr = wr_en ? src_r : (state == RADDR || state == RWAIT) ? dst_r : '0;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = beat && last_l ? WRITE : LOAD;
      WRITE:   nxt = CMD;
      CMD:     nxt = WAIT;
      WAIT:    nxt = wait_end ? RADDR : WAIT;
      RADDR:   nxt = RWAIT;
      RWAIT:   nxt = rd_end ? SEND : RWAIT;
      SEND:    nxt = acc && last_s ? IDLE : SEND;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cmd_r <= CMD_IDLE;
      src_r <= '0;
      dst_r <= '0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      // one counter serves both timed states; it sits at zero everywhere else
      cnt <= (state == WAIT || state == RWAIT) && !wait_end && !rd_end ? cnt + 1'b1 : '0;
      done <= acc && last_s;
      if (idle && start) begin
        cmd_r <= start_cmd;
        src_r <= src_addr;
        dst_r <= dst_addr;
      end
    end
  end
  width_serdes #(.Data(Data), .WORD(WORD), .OW(Data)) u_load (
    .clk(clk), .rst(rst), .clr(idle), .ld(1'b0), .par_in('0),
    .step(beat), .word_in(in_data), .q(Data_in), .last(last_l)
  );
  width_serdes #(.Data(Data), .WORD(WORD), .OW(WORD)) u_send (
    .clk(clk), .rst(rst), .clr(idle), .ld(rd_end), .par_in(Data_Out),
    .step(acc), .word_in('0), .q(out_data), .last(last_s)
  );
endmodule

// File: tb/tb_inverse_host_sequencer.sv
// tb_inverse_host_sequencer: directed bench for the sequencer against small RAM models
module tb_inverse_host_sequencer;
  import inverse_host_sequencer_pkg::*;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 1;
  logic [5:0] start_cmd = 0, src_addr = 0, dst_addr = 0;
  logic [31:0] in_data = 0;
  logic busy, done, in_ready, out_valid, out_last, wr_en;
  logic [5:0] Addr, Command;
  logic [255:0] Data_in, Data_Out;
  logic [31:0] out_data;
  logic busy2, done2, in_ready2, out_valid2, out_last2, wr_en2;
  logic [5:0] addr2, cmd2;
  logic [255:0] din2, dout2, s1;
  logic [31:0] out_data2;
  logic [255:0] mem1 [64];
  logic [255:0] mem2 [64];
  logic [255:0] res, op1, op2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  inverse_host_sequencer #(.CMD_CYCLES(4), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .start_cmd(start_cmd), .src_addr(src_addr), .dst_addr(dst_addr),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .wr_en(wr_en), .Addr(Addr), .Data_in(Data_in), .Data_Out(Data_Out), .Command(Command)
  );
  inverse_host_sequencer #(.CMD_CYCLES(1), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .start_cmd(start_cmd), .src_addr(src_addr), .dst_addr(dst_addr),
    .busy(busy2), .done(done2), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_last(out_last2),
    .wr_en(wr_en2), .Addr(addr2), .Data_in(din2), .Data_Out(dout2), .Command(cmd2)
  );
  always @(posedge clk) begin
    if (wr_en) mem1[Addr] <= Data_in;
    Data_Out <= mem1[Addr];
    if (wr_en2) mem2[addr2] <= din2;
    s1 <= mem2[addr2];
    dout2 <= s1;
  end
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_reset();
    check("rst_ctl", {busy, done, in_ready, out_valid, out_last, wr_en}, 6'b0);
    check("rst_addr", Addr, 0);
    check("rst_cmd", Command, CMD_IDLE);
    check("rst_din", Data_in, 0);
    check("rst_dout", out_data, 0);
  endtask
  task automatic op(input logic [5:0] cmd, input logic [5:0] src, input logic [5:0] dst,
                    input bit gaps, input int stall_at, input bit poke, input logic [255:0] operand);
    int k, j, stall, t;
    bit ph;
    start = 1; start_cmd = cmd; src_addr = src; dst_addr = dst; in_valid = 1; in_data = '1;
    @(negedge clk);
    start = 0; start_cmd = 0; src_addr = 0; dst_addr = 0;
    k = 0; ph = 0; t = 0;
    while (k < 8 && t < 64) begin
      check("in_ready", in_ready, 1);
      check("no_early_wr", wr_en, 0);
      in_valid = gaps ? !ph : 1'b1;
      ph = !ph;
      in_data = operand[k*32 +: 32];
      @(negedge clk);
      if (in_valid) k++;
      t++;
    end
    in_valid = 0;
    check("wr_en", wr_en, 1);
    check("wr_addr", Addr, src);
    check("operand", Data_in, operand);
    check("in_ready_low", in_ready, 0);
    @(negedge clk);
    check("cmd_issue", Command, cmd);
    check("wr_once", wr_en, 0);
    check("ram_wr", mem1[src], operand);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      check("wait_cmd", Command, CMD_IDLE);
      check("wait_busy", busy, 1);
      check("wait_addr", Addr, 0);
      if (poke) begin
        start = w == 0;
        start_cmd = 6'h2A;
      end
    end
    start = 0;
    @(negedge clk);
    check("rd_addr", Addr, dst);
    check("rd_cmd", Command, CMD_IDLE);
    @(negedge clk);
    check("rwait_addr", Addr, dst);
    check("rwait_valid", out_valid, 0);
    @(negedge clk);
    j = 0; stall = 0; t = 0;
    while (j < 8 && t < 64) begin
      check("out_valid", out_valid, 1);
      check("out_data", out_data, res[j*32 +: 32]);
      check("out_last", out_last, j == 7);
      check("done_low", done, 0);
      out_ready = !(j == stall_at && stall < 3);
      if (!out_ready) stall++;
      @(negedge clk);
      if (out_ready) j++;
      t++;
    end
    out_ready = 1;
    check("done", done, 1);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask
  task automatic mon2();
    bit found = 0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (cmd2 != CMD_IDLE) found = 1;
    end
    check("d2_cmd_seen", found, 1);
    if (found) begin
      check("d2_cmd", cmd2, OP_INV);
      @(negedge clk);
      check("d2_wait", {addr2, cmd2}, 0);
      check("d2_busy", busy2, 1);
      @(negedge clk);
      check("d2_raddr", addr2, 3);
      @(negedge clk);
      check("d2_rwait1", {addr2, out_valid2}, {6'd3, 1'b0});
      @(negedge clk);
      check("d2_rwait2", {addr2, out_valid2}, {6'd3, 1'b0});
      @(negedge clk);
      check("d2_send", {out_valid2, out_last2, in_ready2}, 3'b100);
      check("d2_word0", out_data2, res[31:0]);
    end
  endtask
  initial begin
    for (int j = 0; j < 8; j++) begin
      res[j*32 +: 32] = 32'hA5A5_0000 + j;
      op1[j*32 +: 32] = j;
      op2[j*32 +: 32] = 32'h1000_0000 + j * 32'h0101_0101;
    end
    for (int i = 0; i < 64; i++) begin
      mem1[i] <= '0;
      mem2[i] <= {8{32'hDEAD_BEEF}};
    end
    mem1[3] <= res;
    mem2[3] <= res;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 0;
    @(negedge clk);
    fork
      op(OP_INV, 6'd2, 6'd3, 0, -1, 0, op1);
      mon2();
    join
    op(OP_MUL, 6'd2, 6'd3, 1, -1, 0, op2);
    op(OP_INV, 6'd2, 6'd3, 0, 2, 0, op1);
    op(OP_INV, 6'd2, 6'd3, 0, -1, 1, op2);
    start = 1; start_cmd = OP_INV; src_addr = 6'd2; dst_addr = 6'd3;
    @(negedge clk);
    start = 0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1;
      in_data = 32'h5555_0000 + b;
      @(negedge clk);
    end
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    chk_reset();
    rst = 0;
    @(negedge clk);
    check("post_rst_wr", {wr_en, wr_en2, busy, busy2}, 4'b0);
    op(OP_INV, 6'd2, 6'd3, 0, -1, 0, op2 ^ op1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
